vector_fma_pipe: RTL and testbench
==================================

Name: vector_fma_pipe

Overview:
Parametrised, back-pressurable integer vector fused multiply-add unit. It is the successor to the fixed 8x64-bit FMA. It adds configurable lane count, lane width and depth, four sign modes, per-lane merge masking, a tag side-band, valid/ready flow control and pipeline flush. It sits in the vector execute cluster between issue (upstream) and writeback/result bus (downstream).

Parameters:
LANES, 8, number of independent lanes (>=1)
LANE_W, 64, bits per lane (8/16/32/64)
STAGES, 5, pipeline depth and unstalled latency in cycles (>=1)
TAG_W, 6, width of opaque tag carried alongside each operation

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush_i  in  1  synchronous kill of all in-flight ops
valid_i  in  1  operation offered
ready_o  out  1  unit can accept this cycle
op_i  in  2  sign mode: 0 FMADD, 1 FMSUB, 2 FNMADD, 3 FNMSUB
mask_i  in  LANES  per-lane enable; 0 = merge src3
tag_i  in  TAG_W  tag returned with result
src1_i  in  LANES*LANE_W  multiplicand vector, lane k at [k*LANE_W +: LANE_W]
src2_i  in  LANES*LANE_W  multiplier vector
src3_i  in  LANES*LANE_W  addend / merge-old-destination vector
valid_o  out  1  result present
ready_i  in  1  downstream accepts result
result_o  out  LANES*LANE_W  result vector
tag_o  out  TAG_W  tag of result

Behaviour:
- Accept when valid_i && ready_o && !flush_i. Deliver when valid_o && ready_i.
- Arithmetic per lane is mod 2^LANE_W. p = low LANE_W bits of src1*src2; signedness is irrelevant to the low bits.
  - FMADD = p + c
  - FMSUB = p - c
  - FNMADD = -p + c
  - FNMSUB = -p - c
  - Negation is two's complement. No saturation, no flags.
- mask_i[k]=0: lane k result = src3 lane k unchanged, for all ops.
- Computation happens in stage 0. Stages 1..STAGES-1 carry {valid, result, tag}.
- Per-stage advance: adv[S-1] = ready_i. adv[i] = !v[i+1] || adv[i+1]. Stage i loads from stage i-1 when adv[i].
- Bubbles collapse: an empty stage always accepts from the stage behind it.
- ready_o = (!v[0] || adv[0]) && !flush_i. It is combinational from ready_i and the valid bits.
- Latency: exactly STAGES cycles from accept edge to valid_o when never stalled. Throughput: 1 op/cycle.
- ready_i low: valid_o and result_o/tag_o hold stable until taken (no data change while valid_o && !ready_i). Upstream stages fill; ready_o drops once all STAGES hold valid data. Ops are never dropped or reordered.
- flush_i=1: all v[] cleared at the next edge, including the output stage even if ready_i=1 that cycle. That cycle's output handshake still counts as delivered if valid_o && ready_i. ready_o=0 during flush, so valid_i is ignored. Next cycle ready_o=1.
- Data registers are not cleared by flush; valid_o=0 qualifies them.
- Reset (asynchronous, any time, including mid-stall) forces:
  - all valids=0 → valid_o=0 immediately
  - result_o=0, tag_o=0 (all data registers zeroed)
  - after release, ready_o=1
- STAGES=1: compute register feeds outputs directly; same rules apply.

Decomposition:
- vector_fma_pkg holds:
  - fma_op_e enum (FMADD=0, FMSUB=1, FNMADD=2, FNMSUB=3)
  - default LANES/LANE_W/STAGES/TAG_W localparams
  - helper function lane slice index
- Sub-module vector_fma_lane (combinational; params LANE_W; ports a, b, c, op, en → r), instantiated LANES times by generate in vector_fma_pipe.
- Stage control (valid/advance chain) stays in the top module.

Test Plan:
- FMADD, all lanes src1=3, src2=4, src3=5, mask=0xFF, tag=0x2A, ready_i=1 → valid_o exactly 5 cycles after accept; every lane=17; tag_o=0x2A.
- FMSUB src1=0xFFFF_FFFF_FFFF_FFFF (-1), src2=2, src3=1 → every lane 0xFFFF_FFFF_FFFF_FFFD. FNMSUB 3,4,5 → every lane 0xFFFF_FFFF_FFFF_FFEF (-17).
- mask=0x0F, FMADD 3,4,src3=0xDEAD → lanes 0-3=0xDEB9, lanes 4-7=0xDEAD.
- Stream 12 back-to-back ops (tags 0..11); hold ready_i=0 for 8 cycles starting at first valid_o:
  - ready_o falls after exactly 5 buffered ops
  - result_o/tag_o stable while held
  - all 12 delivered in tag order, none lost or duplicated
- Issue 3 ops, assert flush_i one cycle while 3 are in flight → none emerge; op accepted the cycle after flush emerges 5 cycles later; ready_o=0 only during flush cycle.
- Assert rst mid-stream with valid_o=1 and ready_i=0 → valid_o, result_o, tag_o go to 0 without waiting for a clock edge; after release, ready_o=1 and a fresh op completes with latency 5.

Source files
------------

// File: rtl/vector_fma_pkg.sv
// Shared types and defaults for the vector fused multiply-add pipeline.
// The op encoding puts the product sign in bit 1 and the addend sign in bit 0.
package vector_fma_pkg;

  typedef enum logic [1:0] {
    FMADD  = 2'd0,
    FMSUB  = 2'd1,
    FNMADD = 2'd2,
    FNMSUB = 2'd3
  } fma_op_e;

  localparam int DEF_LANES  = 8;
  localparam int DEF_LANE_W = 64;
  localparam int DEF_STAGES = 5;
  localparam int DEF_TAG_W  = 6;

  // Low bit index of a lane inside a packed lane vector.
  function automatic int lane_lo(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/vector_fma_lane.sv
// One combinational FMA lane: r = (+/-)(a*b) (+/-) c, or c when the lane is masked off.
// Only the low LANE_W product bits are kept, so signed and unsigned operands agree.
module vector_fma_lane
  import vector_fma_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [LANE_W-1:0] c,
  input  fma_op_e           op,
  input  logic              en,
  output logic [LANE_W-1:0] r
);

  logic [LANE_W-1:0] p;
  logic [LANE_W-1:0] sum;

  assign p = a * b;

  always_comb begin
    sum = p + c;
    case (op)
      FMADD:   sum = p + c;
      FMSUB:   sum = p - c;
      FNMADD:  sum = c - p;
      FNMSUB:  sum = '0 - p - c;
      default: sum = p + c;
    endcase
  end

  assign r = en ? sum : c;

endmodule

// File: rtl/vector_fma_pipe.sv
// Back-pressurable vector FMA: compute into stage 0, then carry {valid, result, tag}
// through STAGES-1 skid-free pipeline registers with bubble collapsing and flush.
module vector_fma_pipe
  import vector_fma_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int STAGES = DEF_STAGES,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [1:0]              op_i,
  input  logic [LANES-1:0]        mask_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [LANES*LANE_W-1:0] src1_i,
  input  logic [LANES*LANE_W-1:0] src2_i,
  input  logic [LANES*LANE_W-1:0] src3_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [LANES*LANE_W-1:0] result_o,
  output logic [TAG_W-1:0]        tag_o
);

  localparam int DATA_W = LANES * LANE_W;

  fma_op_e           op;
  logic [DATA_W-1:0] lane_res;
  logic [STAGES-1:0] v_reg;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [DATA_W-1:0] data_reg [STAGES];
  logic [TAG_W-1:0]  tag_reg  [STAGES];
  logic              accept;

  assign op = fma_op_e'(op_i);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      vector_fma_lane #(
        .LANE_W(LANE_W)
      ) u_lane (
        .a (src1_i[lane_lo(gi, LANE_W) +: LANE_W]),
        .b (src2_i[lane_lo(gi, LANE_W) +: LANE_W]),
        .c (src3_i[lane_lo(gi, LANE_W) +: LANE_W]),
        .op(op),
        .en(mask_i[gi]),
        .r (lane_res[lane_lo(gi, LANE_W) +: LANE_W])
      );
    end
  endgenerate

  // adv[i]: whatever stage i holds can move on this cycle.
  // load[i]: stage i takes new contents (it is empty or draining).
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ready_i;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = !v_reg[i+1] || adv[i+1];
    end
    load = ~v_reg | adv;
  end

  assign ready_o = load[0] && !flush_i;
  assign accept  = valid_i && ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_reg[i] <= '0;
        tag_reg[i]  <= '0;
      end
    end else begin
      if (load[0]) begin
        v_reg[0] <= accept;
      end
      if (accept) begin
        data_reg[0] <= lane_res;
        tag_reg[0]  <= tag_i;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          v_reg[i] <= v_reg[i-1];
          if (v_reg[i-1]) begin
            data_reg[i] <= data_reg[i-1];
            tag_reg[i]  <= tag_reg[i-1];
          end
        end
      end
      // Flush wins over any movement; data stays, the cleared valids disqualify it.
      if (flush_i) begin
        v_reg <= '0;
      end
    end
  end

  assign valid_o  = v_reg[STAGES-1];
  assign result_o = data_reg[STAGES-1];
  assign tag_o    = tag_reg[STAGES-1];

endmodule

// File: tb/tb_vector_fma_pipe.sv
// Self-checking bench for vector_fma_pipe: fixed vectors, stall, flush, reset and random traffic
// checked in order against a lane-arithmetic reference model and a FIFO scoreboard.
module tb_vector_fma_pipe;
  import vector_fma_pkg::*;

  localparam int LANES  = 8;
  localparam int LW     = 64;
  localparam int STAGES = 5;
  localparam int TW     = 6;
  localparam int DW     = LANES * LW;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [1:0]        op_i;
  logic [LANES-1:0]  mask_i;
  logic [TW-1:0]     tag_i;
  logic [DW-1:0]     src1_i;
  logic [DW-1:0]     src2_i;
  logic [DW-1:0]     src3_i;
  logic              valid_o;
  logic              ready_i;
  logic [DW-1:0]     result_o;
  logic [TW-1:0]     tag_o;

  always #5 clk = ~clk;

  vector_fma_pipe #(
    .LANES (LANES),
    .LANE_W(LW),
    .STAGES(STAGES),
    .TAG_W (TW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .mask_i  (mask_i),
    .tag_i   (tag_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .src3_i  (src3_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o),
    .tag_o   (tag_o)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    int            acc_cyc;
  } item_t;

  typedef struct {
    logic [1:0]       op;
    logic [LANES-1:0] mask;
    logic [LW-1:0]    a;
    logic [LW-1:0]    b;
    logic [LW-1:0]    c;
    logic [TW-1:0]    tag;
    logic [LW-1:0]    exp_on;
  } vec_t;

  item_t         exp_q[$];
  vec_t          tbl[6];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            deliv_cnt = 0;
  bit            lat_chk = 1'b0;
  bit            acc_flag = 1'b0;
  logic [DW-1:0] cur_exp;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference lane arithmetic: product sign from op bit 1, addend sign from op bit 0.
  function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [LANES-1:0] m,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
    logic [DW-1:0]   r;
    logic [2*LW-1:0] full;
    logic [LW-1:0]   p, ck, tp, tc;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      full = {{LW{1'b0}}, a[k*LW +: LW]} * {{LW{1'b0}}, b[k*LW +: LW]};
      p    = full[LW-1:0];
      ck   = c[k*LW +: LW];
      tp   = op[1] ? ({LW{1'b0}} - p) : p;
      tc   = op[0] ? ({LW{1'b0}} - ck) : ck;
      r[k*LW +: LW] = m[k] ? (tp + tc) : ck;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [LANES-1:0] m, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] c, input logic [TW-1:0] t,
                       input logic [DW-1:0] e);
    valid_i = 1'b1;
    op_i    = op;
    mask_i  = m;
    src1_i  = a;
    src2_i  = b;
    src3_i  = c;
    tag_i   = t;
    cur_exp = e;
  endtask

  task automatic drive_rand(input logic [TW-1:0] t);
    logic [1:0]       op;
    logic [LANES-1:0] m;
    logic [DW-1:0]    a, b, c;
    op = 2'($urandom_range(3));
    m  = LANES'($urandom);
    a  = rand_vec();
    b  = rand_vec();
    c  = rand_vec();
    drive(op, m, a, b, c, t, model(op, m, a, b, c));
  endtask

  // One clock: sample both handshakes at the falling edge, then step to just after the rising edge.
  task automatic tick();
    item_t it;
    @(negedge clk);
    acc_flag = 1'b0;
    if (valid_o && ready_i) begin
      deliv_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL deliver_unexpected: got tag %0d, required no delivery", tag_o);
      end else begin
        it = exp_q.pop_front();
        check("deliver_result", result_o, it.res);
        check("deliver_tag", DW'(tag_o), DW'(it.tag));
        if (lat_chk) check("latency", DW'(cyc - it.acc_cyc), DW'(STAGES));
      end
    end
    if (valid_i && ready_o && !flush_i) begin
      it.res     = cur_exp;
      it.tag     = tag_i;
      it.acc_cyc = cyc;
      exp_q.push_back(it);
      acc_cnt++;
      acc_flag = 1'b1;
    end
    if (flush_i) exp_q.delete();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_deliv(input string name, input int target, input int bound);
    for (int w = 0; w < bound && deliv_cnt < target; w++) tick();
    if (deliv_cnt < target) bound_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]    va, vb, vc, ve, held_res;
    logic [TW-1:0]    held_tag;
    logic [1:0]       s_op[12];
    logic [LANES-1:0] s_m[12];
    logic [DW-1:0]    s_a[12], s_b[12], s_c[12];
    int               idx, hold, d0, a0;
    bit               started, ro_seen;

    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    op_i = '0; mask_i = '0; tag_i = '0; src1_i = '0; src2_i = '0; src3_i = '0; cur_exp = '0;

    tbl[0] = '{op: 2'd0, mask: 8'hFF, a: 64'd3, b: 64'd4, c: 64'd5, tag: 6'h2A, exp_on: 64'd17};
    tbl[1] = '{op: 2'd1, mask: 8'hFF, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2, c: 64'd1, tag: 6'h01,
               exp_on: 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[2] = '{op: 2'd3, mask: 8'hFF, a: 64'd3, b: 64'd4, c: 64'd5, tag: 6'h02,
               exp_on: 64'hFFFF_FFFF_FFFF_FFEF};
    tbl[3] = '{op: 2'd0, mask: 8'h0F, a: 64'd3, b: 64'd4, c: 64'hDEAD, tag: 6'h03, exp_on: 64'hDEB9};
    tbl[4] = '{op: 2'd2, mask: 8'hFF, a: 64'd3, b: 64'd4, c: 64'd5, tag: 6'h04,
               exp_on: 64'hFFFF_FFFF_FFFF_FFF9};
    tbl[5] = '{op: 2'd1, mask: 8'hA5, a: 64'd3, b: 64'd4, c: 64'd5, tag: 6'h3F, exp_on: 64'd7};

    // Reset state, before any clock edge.
    #1;
    check("reset_valid_o", DW'(valid_o), DW'(0));
    check("reset_result_o", result_o, '0);
    check("reset_tag_o", DW'(tag_o), DW'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_ready_o", DW'(ready_o), DW'(1));

    // Fixed vectors, one op at a time, unstalled.
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      va = {LANES{tbl[i].a}};
      vb = {LANES{tbl[i].b}};
      vc = {LANES{tbl[i].c}};
      for (int k = 0; k < LANES; k++) ve[k*LW +: LW] = tbl[i].mask[k] ? tbl[i].exp_on : tbl[i].c;
      d0 = deliv_cnt;
      drive(tbl[i].op, tbl[i].mask, va, vb, vc, tbl[i].tag, ve);
      tick();
      valid_i = 1'b0;
      wait_deliv("table_delivery", d0 + 1, 20);
    end

    // Back-to-back stream of 12 with an 8-cycle stall starting at the first result.
    lat_chk = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_op[i] = 2'($urandom_range(3));
      s_m[i]  = LANES'($urandom);
      s_a[i]  = rand_vec();
      s_b[i]  = rand_vec();
      s_c[i]  = rand_vec();
    end
    idx = 0; hold = 0; started = 1'b0; ro_seen = 1'b0; d0 = deliv_cnt; a0 = acc_cnt;
    held_res = '0; held_tag = '0;
    for (int g = 0; g < 200 && (deliv_cnt - d0) < 12; g++) begin
      if (idx < 12)
        drive(s_op[idx], s_m[idx], s_a[idx], s_b[idx], s_c[idx], TW'(idx),
              model(s_op[idx], s_m[idx], s_a[idx], s_b[idx], s_c[idx]));
      else
        valid_i = 1'b0;
      if (!started && valid_o) begin
        started = 1'b1; hold = 8; held_res = result_o; held_tag = tag_o;
      end else if (hold > 0) begin
        check("hold_result", result_o, held_res);
        check("hold_tag", DW'(tag_o), DW'(held_tag));
      end
      ready_i = (hold == 0);
      #1;
      if (!ro_seen && !ready_o && idx < 12) begin
        ro_seen = 1'b1;
        check("buffered_at_ready_low", DW'((acc_cnt - a0) - (deliv_cnt - d0)), DW'(STAGES));
      end
      tick();
      if (acc_flag) idx++;
      if (hold > 0) hold--;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (8) tick();
    if (!ro_seen) bound_fail("stall_ready_low");
    check("stream_delivered", DW'(deliv_cnt - d0), DW'(12));
    check("stream_accepted", DW'(acc_cnt - a0), DW'(12));

    // Flush with three ops in flight; only the op after the flush may emerge.
    lat_chk = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive_rand(TW'(j + 32));
      tick();
    end
    drive_rand(TW'(40));
    flush_i = 1'b1;
    #1 check("flush_ready_o", DW'(ready_o), DW'(0));
    tick();
    flush_i = 1'b0;
    drive_rand(TW'(21));
    #1 check("post_flush_ready_o", DW'(ready_o), DW'(1));
    d0 = deliv_cnt;
    tick();
    valid_i = 1'b0;
    repeat (15) tick();
    check("post_flush_delivered", DW'(deliv_cnt - d0), DW'(1));

    // Asynchronous reset while a result is stalled at the output.
    lat_chk = 1'b0;
    ready_i = 1'b0;
    for (int g = 0; g < 20 && !valid_o; g++) begin
      drive_rand(TW'(g + 1));
      tick();
    end
    if (!valid_o) bound_fail("reset_setup_valid_o");
    #2 rst = 1'b1;
    #1;
    check("async_reset_valid_o", DW'(valid_o), DW'(0));
    check("async_reset_result_o", result_o, '0);
    check("async_reset_tag_o", DW'(tag_o), DW'(0));
    exp_q.delete();
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("after_reset_ready_o", DW'(ready_o), DW'(1));
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    d0 = deliv_cnt;
    drive_rand(TW'(9));
    tick();
    valid_i = 1'b0;
    wait_deliv("after_reset_delivery", d0 + 1, 20);

    // Random traffic with back-pressure and occasional flushes.
    lat_chk = 1'b0;
    for (int g = 0; g < 400; g++) begin
      drive_rand(TW'($urandom));
      valid_i = ($urandom_range(3) != 0);
      ready_i = ($urandom_range(2) != 0);
      flush_i = ($urandom_range(49) == 0);
      tick();
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (20) tick();
    check("random_drained", DW'(exp_q.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
